mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in storage; power of two, at least 4.
REQ-002 Parameter LATENCY, default 2, wait cycles between request accept and response; range 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  processor request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  request type: 1 store, 0 load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  processor accepts the response.
REQ-012 rsp_rdata  output  32  load data; 0 for store responses.
REQ-013 rsp_err  output  1  request was rejected (see REQ-027).

Function
REQ-014 A request is accepted on a rising edge where req_valid=1 and req_ready=1; req_write, req_addr and req_wdata are captured on that edge.
REQ-015 The FSM has three states: IDLE, WAIT and RESP.
REQ-016 IDLE: req_ready=1; on accept, go to WAIT when LATENCY>0, otherwise go to RESP.
REQ-017 WAIT: req_ready=0; the wait counter loads LATENCY-1 on accept and decrements each cycle; at 0, go to RESP.
REQ-018 Result: accept-to-rsp_valid latency is exactly LATENCY+1 cycles.
REQ-019 Memory access happens on the edge entering RESP: a store writes the captured word; a load registers the word into rsp_rdata.
REQ-020 RESP: rsp_valid=1 and rsp_rdata/rsp_err are held stable until rsp_ready=1; on that edge go to IDLE, drop rsp_valid and clear rsp_rdata and rsp_err to 0.
REQ-021 req_ready is 0 in WAIT and RESP; requests arriving then are ignored, not queued.
REQ-022 The word index is req_addr[log2(DEPTH)+1:2].
REQ-023 A load following a store to the same address returns the stored data (no stale read).
REQ-024 A store response has rsp_rdata=0.

Reset
REQ-025 While reset=0: state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
REQ-026 Reset asserted mid-operation: the pending request is abandoned, no write is committed, storage contents are preserved, and req_ready rises on the first rising edge after reset=1.

Configuration
REQ-027 With MEM_RESPONDER_ERR_CHECK_EN defined: a request with req_addr[1:0]!=0, or req_addr >= DEPTH*4, still takes full latency, answers with rsp_err=1 and rsp_rdata=0, and never modifies storage.
REQ-028 Without MEM_RESPONDER_ERR_CHECK_EN: rsp_err is tied 0, the low two address bits are ignored, and the address wraps modulo DEPTH words.

Structure
REQ-029 Shared package mem_resp_pkg holds the state enum (IDLE/WAIT/RESP), the word-width constant (32) and the counter-width constant (4).
REQ-030 Sub-module mem_array holds the storage: one synchronous write port and one registered read port, instantiated once.

Verification
REQ-031 Reset: hold reset=0 for 3 cycles, then release -> during reset all outputs are 0; req_ready=1 one cycle after release.
REQ-032 Round trip, LATENCY=2, rsp_ready=1: store 0xDEADBEEF to 0x10, then load 0x10 -> each rsp_valid appears 3 cycles after accept; the load returns rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-033 Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable; req_ready=0; a second req_valid is ignored; rsp_ready=1 -> IDLE next cycle.
REQ-034 LATENCY=0: store 0x1 to 0x0 -> rsp_valid on the cycle after accept; a back-to-back load of 0x0 returns 0x1.
REQ-035 Error (macro defined, DEPTH=256): store to 0x402 -> rsp_err=1; a store to 0x400 -> rsp_err=1; a load of word 0 is unchanged. Macro undefined: a store to 0x400 writes word 0.
REQ-036 Reset during WAIT of a store 0x55 to 0x20 -> no rsp_valid; a later load of 0x20 returns the prior contents.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared state encoding and widths for the memory responder and its storage.
package mem_resp_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a processor (master) and the memory responder (slave).
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Word storage: one synchronous write port and one registered read port.
module mem_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WORD_W-1:0]        rd_data
);

    logic [WORD_W-1:0] words [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            words[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= words[rd_addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder answering LATENCY+1 cycles after accept.
// Optional MEM_RESPONDER_ERR_CHECK_EN rejects misaligned or out-of-range addresses with rsp_err.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t            state;
    state_t            next_state;
    logic              ready_en;
    logic              accept;
    logic              enter_resp;
    logic              ready;
    logic              resp_active;
    logic [CNT_W-1:0]  cnt;

    logic              write_p0;
    logic [WORD_W-1:0] addr_p0;
    logic [WORD_W-1:0] wdata_p0;

    logic              sel_write;
    logic [WORD_W-1:0] sel_addr;
    logic [WORD_W-1:0] sel_wdata;
    logic [AW-1:0]     index;
    logic              bad_addr;
    logic              wr_en;
    logic              rd_en;

    logic              err_q;
    logic              load_q;
    logic [WORD_W-1:0] mem_rdata;

    // Request capture stage: fields are held for the WAIT period
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0 <= bus.req_write;
            addr_p0  <= bus.req_addr;
            wdata_p0 <= bus.req_wdata;
        end
    end

    // With LATENCY=0 memory is accessed on the accept edge itself, so use the live bus
    assign sel_write = (state == IDLE) ? bus.req_write : write_p0;
    assign sel_addr  = (state == IDLE) ? bus.req_addr  : addr_p0;
    assign sel_wdata = (state == IDLE) ? bus.req_wdata : wdata_p0;
    assign index     = sel_addr[AW+1:2];

`ifdef MEM_RESPONDER_ERR_CHECK_EN
    assign bad_addr = (sel_addr[1:0] != 2'b00) || (sel_addr[WORD_W-1:AW+2] != '0);
`else
    assign bad_addr = 1'b0;
    wire unused_addr_bits = ^{sel_addr[1:0], sel_addr[WORD_W-1:AW+2]};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        ready       = 1'b0;
        resp_active = 1'b0;
        case (state)
            IDLE: begin
                ready = ready_en;
                if (bus.req_valid && ready_en) begin
                    accept     = 1'b1;
                    next_state = (LATENCY > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                resp_active = 1'b1;
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign enter_resp = (next_state == RESP) && (state != RESP);
    assign wr_en      = enter_resp && sel_write && !bad_addr;
    assign rd_en      = enter_resp && !sel_write && !bad_addr;

    // Response stage: flags are set on the edge entering RESP and cleared on handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en <= 1'b0;
            cnt      <= '0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (enter_resp) begin
                err_q  <= bad_addr;
                load_q <= !sel_write && !bad_addr;
            end else if (state == RESP && bus.rsp_ready) begin
                err_q  <= 1'b0;
                load_q <= 1'b0;
            end
        end
    end

    mem_array #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (index),
        .wr_data (sel_wdata),
        .rd_en   (rd_en),
        .rd_addr (index),
        .rd_data (mem_rdata)
    );

    assign bus.req_ready = ready;
    assign bus.rsp_valid = resp_active;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = load_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=2 and one LATENCY=0 instance on a shared clock/reset.
module tb_mem_responder;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total  = 0;

`ifdef MEM_RESPONDER_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_responder_if bus2();
    mem_responder_if bus0();

    mem_responder #(.DEPTH(256), .LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    // Issue one request on the LATENCY=2 instance starting at a negedge; latency is counted in
    // negedges after the accept edge. Without hold the response is consumed before returning.
    task automatic req2(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic hold, output int lat, output logic [31:0] rd, output logic er);
        bus2.rsp_ready = !hold;
        bus2.req_valid = 1'b1;
        bus2.req_write = wr;
        bus2.req_addr  = addr;
        bus2.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        lat = 1;
        while (bus2.rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = bus2.rsp_rdata;
        er = bus2.rsp_err;
        if (!hold) @(negedge clk);
    endtask

    task automatic req0(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
        bus0.rsp_ready = 1'b1;
        bus0.req_valid = 1'b1;
        bus0.req_write = wr;
        bus0.req_addr  = addr;
        bus0.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        lat = 1;
        while (bus0.rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = bus0.rsp_rdata;
        er = bus0.rsp_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({bus2.req_ready, bus2.rsp_valid, bus2.rsp_err} !== 3'b000 || bus2.rsp_rdata !== 32'h0) begin
                $display("FAIL reset_outputs cycle %0d: ready=%b valid=%b err=%b rdata=%h, required all 0",
                         i, bus2.req_ready, bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata);
            end else passed++;
            total++;
            if ({bus0.req_ready, bus0.rsp_valid, bus0.rsp_err} !== 3'b000 || bus0.rsp_rdata !== 32'h0) begin
                $display("FAIL reset_outputs_lat0 cycle %0d: ready=%b valid=%b err=%b rdata=%h, required all 0",
                         i, bus0.req_ready, bus0.rsp_valid, bus0.rsp_err, bus0.rsp_rdata);
            end else passed++;
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus2.req_ready !== 1'b0) begin
            $display("FAIL ready_before_edge: got %b, required 0", bus2.req_ready);
        end else passed++;
        @(negedge clk);
        total++;
        if (bus2.req_ready !== 1'b1) begin
            $display("FAIL ready_after_release: got %b, required 1", bus2.req_ready);
        end else passed++;
        total++;
        if (bus0.req_ready !== 1'b1) begin
            $display("FAIL ready_after_release_lat0: got %b, required 1", bus0.req_ready);
        end else passed++;
    endtask

    task automatic test_round_trip();
        int lat;
        logic [31:0] rd;
        logic er;
        req2(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, rd, er);
        total++;
        if (lat != 3) begin
            $display("FAIL store_latency: got %0d, required 3", lat);
        end else passed++;
        total++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            $display("FAIL store_response: rdata=%h err=%b, required 0/0", rd, er);
        end else passed++;
        req2(1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er);
        total++;
        if (lat != 3) begin
            $display("FAIL load_latency: got %0d, required 3", lat);
        end else passed++;
        total++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            $display("FAIL load_data: rdata=%h err=%b, required deadbeef/0", rd, er);
        end else passed++;
        total++;
        if (bus2.rsp_valid !== 1'b0 || bus2.rsp_rdata !== 32'h0 || bus2.req_ready !== 1'b1) begin
            $display("FAIL after_handshake: valid=%b rdata=%h ready=%b, required 0/0/1",
                     bus2.rsp_valid, bus2.rsp_rdata, bus2.req_ready);
        end else passed++;
    endtask

    task automatic test_backpressure();
        int lat;
        int seen;
        logic [31:0] rd;
        logic er;
        req2(1'b1, 32'h14, 32'h12345678, 1'b0, lat, rd, er);
        req2(1'b0, 32'h14, 32'h0, 1'b1, lat, rd, er);
        total++;
        if (lat != 3 || rd !== 32'h12345678) begin
            $display("FAIL hold_first_response: lat=%0d rdata=%h, required 3/12345678", lat, rd);
        end else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus2.rsp_valid !== 1'b1 || bus2.rsp_rdata !== 32'h12345678 || bus2.req_ready !== 1'b0) begin
                $display("FAIL hold_stable cycle %0d: valid=%b rdata=%h ready=%b, required 1/12345678/0",
                         i, bus2.rsp_valid, bus2.rsp_rdata, bus2.req_ready);
            end else passed++;
            if (i == 1) begin
                bus2.req_valid = 1'b1;
                bus2.req_write = 1'b1;
                bus2.req_addr  = 32'h14;
                bus2.req_wdata = 32'hBAD0BAD0;
            end
            if (i == 3) bus2.req_valid = 1'b0;
            @(negedge clk);
        end
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus2.rsp_valid !== 1'b0 || bus2.req_ready !== 1'b1 || bus2.rsp_rdata !== 32'h0) begin
            $display("FAIL release_to_idle: valid=%b ready=%b rdata=%h, required 0/1/0",
                     bus2.rsp_valid, bus2.req_ready, bus2.rsp_rdata);
        end else passed++;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus2.rsp_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            $display("FAIL ignored_not_queued: extra response cycles=%0d, required 0", seen);
        end else passed++;
        req2(1'b0, 32'h14, 32'h0, 1'b0, lat, rd, er);
        total++;
        if (rd !== 32'h12345678) begin
            $display("FAIL ignored_store_data: rdata=%h, required 12345678", rd);
        end else passed++;
    endtask

    task automatic test_latency0();
        int lat;
        logic [31:0] rd;
        logic er;
        req0(1'b1, 32'h0, 32'h1, lat, rd, er);
        total++;
        if (lat != 1 || rd !== 32'h0 || er !== 1'b0) begin
            $display("FAIL lat0_store: lat=%0d rdata=%h err=%b, required 1/0/0", lat, rd, er);
        end else passed++;
        req0(1'b0, 32'h0, 32'h0, lat, rd, er);
        total++;
        if (lat != 1 || rd !== 32'h1) begin
            $display("FAIL lat0_load: lat=%0d rdata=%h, required 1/00000001", lat, rd);
        end else passed++;
    endtask

    task automatic test_error();
        int lat;
        logic [31:0] rd;
        logic er;
        req2(1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, lat, rd, er);
        req2(1'b1, 32'h402, 32'hFFFF0000, 1'b0, lat, rd, er);
        total++;
        if (lat != 3 || er !== ERR_EN || rd !== 32'h0) begin
            $display("FAIL err_misaligned_store: lat=%0d err=%b rdata=%h, required 3/%b/0", lat, er, rd, ERR_EN);
        end else passed++;
        req2(1'b1, 32'h400, 32'h12121212, 1'b0, lat, rd, er);
        total++;
        if (lat != 3 || er !== ERR_EN || rd !== 32'h0) begin
            $display("FAIL err_range_store: lat=%0d err=%b rdata=%h, required 3/%b/0", lat, er, rd, ERR_EN);
        end else passed++;
        req2(1'b0, 32'h3, 32'h0, 1'b0, lat, rd, er);
        total++;
        if (er !== ERR_EN || rd !== (ERR_EN ? 32'h0 : 32'h12121212)) begin
            $display("FAIL err_misaligned_load: err=%b rdata=%h, required %b/%h",
                     er, rd, ERR_EN, (ERR_EN ? 32'h0 : 32'h12121212));
        end else passed++;
        req2(1'b0, 32'h0, 32'h0, 1'b0, lat, rd, er);
        total++;
        if (er !== 1'b0 || rd !== (ERR_EN ? 32'hA5A5A5A5 : 32'h12121212)) begin
            $display("FAIL err_word0_contents: err=%b rdata=%h, required 0/%h",
                     er, rd, (ERR_EN ? 32'hA5A5A5A5 : 32'h12121212));
        end else passed++;
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        int seen;
        logic [31:0] rd;
        logic er;
        req2(1'b1, 32'h20, 32'h77, 1'b0, lat, rd, er);
        bus2.rsp_ready = 1'b1;
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b1;
        bus2.req_addr  = 32'h20;
        bus2.req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if (bus2.rsp_valid !== 1'b0 || bus2.req_ready !== 1'b0) begin
            $display("FAIL mid_wait_reset_outputs: valid=%b ready=%b, required 0/0", bus2.rsp_valid, bus2.req_ready);
        end else passed++;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus2.rsp_valid === 1'b1) seen++;
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus2.rsp_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            $display("FAIL abandoned_response: response cycles=%0d, required 0", seen);
        end else passed++;
        total++;
        if (bus2.req_ready !== 1'b1) begin
            $display("FAIL ready_after_mid_reset: got %b, required 1", bus2.req_ready);
        end else passed++;
        req2(1'b0, 32'h20, 32'h0, 1'b0, lat, rd, er);
        total++;
        if (lat != 3 || rd !== 32'h77) begin
            $display("FAIL storage_preserved: lat=%0d rdata=%h, required 3/00000077", lat, rd);
        end else passed++;
    endtask

    initial begin
        bus2.req_valid = 1'b0;
        bus2.req_write = 1'b0;
        bus2.req_addr  = 32'h0;
        bus2.req_wdata = 32'h0;
        bus2.rsp_ready = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b0;
        bus0.req_addr  = 32'h0;
        bus0.req_wdata = 32'h0;
        bus0.rsp_ready = 1'b1;
        test_reset();
        test_round_trip();
        test_backpressure();
        test_latency0();
        test_error();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
